// File: rtl/dll_track_lock.sv
// DLL post-acquisition tracking and lock detection.
// Captures the SAR code, then nudges it by +/-1 from a windowed majority
// vote on the phase-detector stream. Lock is declared after a run of
// balanced windows. A run of same-direction steps while locked hands
// control back to the SAR through a one-cycle relock request.
module dll_track_lock #(
  parameter int WIDTH      = 10,
  parameter int WIN        = 8,
  parameter int TH_HI      = 6,
  parameter int TH_LO      = 2,
  parameter int LOCK_HOLDS = 4,
  parameter int LOSS_STEPS = 3
) (
  input  logic             clk4,
  input  logic             rst_n,
  input  logic             sar_done,
  input  logic [WIDTH-1:0] sar_code,
  input  logic             comp,
  output logic [WIDTH-1:0] code,
  output logic             code_valid,
  output logic             lock,
  output logic             relock_req,
  output logic             sat
);

  localparam int WW = $clog2(WIN);
  localparam int OW = $clog2(WIN + 1);
  localparam int HW = $clog2(LOCK_HOLDS + 1);
  localparam int RW = $clog2(LOSS_STEPS + 1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED, RELOCK} state_t;
  typedef enum logic [1:0] {D_HOLD, D_UP, D_DOWN} dec_t;

  state_t         state, state_n;
  logic [WIDTH-1:0] code_n;
  logic [WW-1:0]  win_cnt, win_n;
  logic [OW-1:0]  ones_cnt, ones_n, total;
  logic [HW-1:0]  hold_cnt, hold_n;
  logic [RW-1:0]  run_cnt, run_n;
  logic           dir, dir_n;       // 1 = last step was UP
  logic           lock_n, sat_n;
  dec_t           dec;
  logic [WIDTH:0] stepped;          // {saturated, next code}

  // Majority vote on a completed window.
  function automatic dec_t decide(input logic [OW-1:0] t);
    if (t >= OW'(TH_HI))      return D_DOWN;
    else if (t <= OW'(TH_LO)) return D_UP;
    else                      return D_HOLD;
  endfunction

  // Apply a decision to the code, pinning at the rails and flagging it.
  function automatic logic [WIDTH:0] sat_step(input logic [WIDTH-1:0] c, input dec_t d);
    logic [WIDTH:0] r;
    r = {1'b0, c};
    if (d == D_UP) begin
      if (c == {WIDTH{1'b1}}) r = {1'b1, c};
      else                    r = {1'b0, c + WIDTH'(1)};
    end else if (d == D_DOWN) begin
      if (c == '0) r = {1'b1, c};
      else         r = {1'b0, c - WIDTH'(1)};
    end
    return r;
  endfunction

  assign total      = ones_cnt + {{(OW-1){1'b0}}, comp};
  assign code_valid = (state == TRACK) || (state == LOCKED);
  assign relock_req = (state == RELOCK);

  // State register and loop registers.
  always_ff @(posedge clk4) begin
    if (!rst_n) begin
      state    <= IDLE;
      code     <= '0;
      win_cnt  <= '0;
      ones_cnt <= '0;
      hold_cnt <= '0;
      run_cnt  <= '0;
      dir      <= 1'b0;
      lock     <= 1'b0;
      sat      <= 1'b0;
    end else begin
      state    <= state_n;
      code     <= code_n;
      win_cnt  <= win_n;
      ones_cnt <= ones_n;
      hold_cnt <= hold_n;
      run_cnt  <= run_n;
      dir      <= dir_n;
      lock     <= lock_n;
      sat      <= sat_n;
    end
  end

  // Next-state: capture, window accumulation, decisions, lock/loss tracking.
  always_comb begin
    state_n = state;
    code_n  = code;
    win_n   = win_cnt;
    ones_n  = ones_cnt;
    hold_n  = hold_cnt;
    run_n   = run_cnt;
    dir_n   = dir;
    lock_n  = lock;
    sat_n   = sat;
    dec     = D_HOLD;
    stepped = {sat, code};
    case (state)
      IDLE: begin
        if (sar_done) begin
          code_n  = sar_code;
          state_n = TRACK;
          win_n   = '0;
          ones_n  = '0;
          hold_n  = '0;
          run_n   = '0;
          sat_n   = 1'b0;
        end
      end
      TRACK, LOCKED: begin
        if (win_cnt == WW'(WIN - 1)) begin
          win_n   = '0;
          ones_n  = '0;
          dec     = decide(total);
          stepped = sat_step(code, dec);
          code_n  = stepped[WIDTH-1:0];
          sat_n   = stepped[WIDTH];
          if (state == TRACK) begin
            if (dec == D_HOLD) begin
              if (hold_cnt >= HW'(LOCK_HOLDS - 1)) begin
                hold_n  = HW'(LOCK_HOLDS);
                state_n = LOCKED;
                lock_n  = 1'b1;
                run_n   = '0;
              end else begin
                hold_n = hold_cnt + HW'(1);
              end
            end else begin
              hold_n = '0;
            end
          end else begin
            if (dec == D_HOLD) begin
              run_n = '0;
            end else begin
              // A zero run means no step since the last hold: treat as first step.
              if ((run_cnt != '0) && (dir == (dec == D_UP))) run_n = run_cnt + RW'(1);
              else                                          run_n = RW'(1);
              dir_n = (dec == D_UP);
              if (run_n >= RW'(LOSS_STEPS)) begin
                state_n = RELOCK;
                lock_n  = 1'b0;
              end
            end
          end
        end else begin
          win_n  = win_cnt + WW'(1);
          ones_n = total;
        end
      end
      RELOCK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dll_track_lock.sv
// Scoreboard bench for dll_track_lock: each driven cycle pushes the
// expected outputs, which are popped and compared after the clock edge.
module tb_dll_track_lock;

  logic       clk4 = 1'b0;
  logic       rst_n = 1'b0;
  logic       sar_done = 1'b0;
  logic [9:0] sar_code = '0;
  logic       comp = 1'b0;
  logic [9:0] code;
  logic       code_valid, lock, relock_req, sat;

  dll_track_lock #(.WIDTH(10), .WIN(8), .TH_HI(6), .TH_LO(2),
                   .LOCK_HOLDS(4), .LOSS_STEPS(3)) dut (
    .clk4(clk4), .rst_n(rst_n), .sar_done(sar_done), .sar_code(sar_code),
    .comp(comp), .code(code), .code_valid(code_valid), .lock(lock),
    .relock_req(relock_req), .sat(sat)
  );

  always #5 clk4 = ~clk4;

  typedef struct {
    string      tag;
    logic [9:0] code;
    logic       valid, lock, rq, sat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [9:0] e_code = '0;
  logic       e_valid = 0, e_lock = 0, e_rq = 0, e_sat = 0;
  logic       inject_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare.
  task automatic cyc(input string tag);
    exp_t e;
    sb.push_back('{tag, e_code, e_valid, e_lock, e_rq, e_sat});
    @(posedge clk4);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, " code"},       code,       e.code);
      check({e.tag, " code_valid"}, code_valid, e.valid);
      check({e.tag, " lock"},       lock,       e.lock);
      check({e.tag, " relock_req"}, relock_req, e.rq);
      check({e.tag, " sat"},        sat,        e.sat);
    end
  endtask

  task automatic do_reset(input string tag, input int n);
    rst_n = 0;
    e_code = '0; e_valid = 0; e_lock = 0; e_rq = 0; e_sat = 0;
    for (int i = 0; i < n; i++) cyc(tag);
    rst_n = 1;
  endtask

  task automatic capture(input string tag, input logic [9:0] v);
    sar_done = 1; sar_code = v; comp = 1;
    e_code = v; e_valid = 1; e_lock = 0; e_rq = 0; e_sat = 0;
    cyc(tag);
    sar_done = 0;
  endtask

  // Eight comp samples, LSB first; expectations change only after the 8th.
  task automatic window(input string tag, input logic [7:0] pat, input logic [9:0] nc,
                        input logic nl, input logic nrq, input logic nsat);
    for (int i = 0; i < 8; i++) begin
      comp = pat[i];
      sar_done = inject_done && (i == 0);
      sar_code = 10'h3AA;
      if (i == 7) begin
        e_code = nc; e_lock = nl; e_rq = nrq; e_sat = nsat; e_valid = !nrq;
      end
      cyc(tag);
    end
    sar_done = 0;
  endtask

  initial begin
    // Reset and capture
    do_reset("reset", 2);
    comp = 1; cyc("idle_ignores_comp");
    capture("capture_155", 10'h155);
    do_reset("reset2", 1);

    // Tracking steps and threshold edges
    capture("capture_200", 10'h200);
    window("all_ones_down", 8'hFF, 10'h1FF, 0, 0, 0);
    window("all_zeros_up",  8'h00, 10'h200, 0, 0, 0);
    window("six_ones_down", 8'h3F, 10'h1FF, 0, 0, 0);
    window("two_ones_up",   8'h03, 10'h200, 0, 0, 0);
    window("five_ones_hold", 8'h1F, 10'h200, 0, 0, 0);
    window("three_ones_hold", 8'h07, 10'h200, 0, 0, 0);
    do_reset("reset3", 1);

    // Lock after four balanced windows
    capture("capture_100", 10'h100);
    window("hold1", 8'h55, 10'h100, 0, 0, 0);
    window("hold2", 8'h55, 10'h100, 0, 0, 0);
    window("hold3", 8'h55, 10'h100, 0, 0, 0);
    window("hold4_lock", 8'h55, 10'h100, 1, 0, 0);

    // Loss of lock after three same-direction steps
    window("loss_step1", 8'hFF, 10'h0FF, 1, 0, 0);
    window("loss_step2", 8'hFF, 10'h0FE, 1, 0, 0);
    window("loss_step3", 8'hFF, 10'h0FD, 0, 1, 0);
    e_rq = 0; e_valid = 0;
    cyc("back_to_idle");
    capture("recapture_123", 10'h123);
    inject_done = 1;
    window("sar_done_ignored", 8'h0F, 10'h123, 0, 0, 0);
    inject_done = 0;
    do_reset("reset4", 1);

    // Saturation at zero
    capture("capture_000", 10'h000);
    window("sat_low1", 8'hFF, 10'h000, 0, 0, 1);
    window("sat_low2", 8'hFF, 10'h000, 0, 0, 1);
    window("unsat_low", 8'h00, 10'h001, 0, 0, 0);
    do_reset("reset5", 1);

    // Saturation at full scale
    capture("capture_3FF", 10'h3FF);
    window("sat_high1", 8'h00, 10'h3FF, 0, 0, 1);
    window("sat_high2", 8'h00, 10'h3FF, 0, 0, 1);
    window("unsat_high", 8'hFF, 10'h3FE, 0, 0, 0);
    do_reset("reset6", 1);

    // Reset while locked, with a coincident sar_done
    capture("capture_100b", 10'h100);
    for (int w = 0; w < 3; w++) window("relock_hold", 8'h55, 10'h100, 0, 0, 0);
    window("relock_lock", 8'h55, 10'h100, 1, 0, 0);
    sar_done = 1; sar_code = 10'h2AA; comp = 1;
    do_reset("midop_reset", 1);
    sar_done = 0;
    for (int i = 0; i < 3; i++) cyc("post_reset_idle");

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dll_track_lock.md
Name: dll_track_lock

Overview:
- Post-acquisition tracking and lock-detect stage for the DLL delay-control loop.
- Sits directly downstream of the 10-bit SAR. It captures the SAR's final code when the SAR signals completion.
- It then fine-tracks the phase-detector COMP stream with a windowed majority filter. It steps the code ±1, asserts lock after repeated balanced windows, and requests a new SAR acquisition when lock is lost.
- Its code output drives the delay-line control (coarse decode of code[9:6], fine bits [5:0]).

Parameters:
- WIDTH, 10, width of delay control code
- WIN, 8, COMP samples per decision window (power of two, ≥4)
- TH_HI, 6, ones-count ≥ TH_HI in a window → decrement code
- TH_LO, 2, ones-count ≤ TH_LO in a window → increment code
- LOCK_HOLDS, 4, consecutive hold decisions required to assert lock
- LOSS_STEPS, 3, consecutive same-direction steps while locked that force relock

Ports:
- clk4  in  1  loop clock, rising edge, same clock that steps the SAR
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk4
- sar_done  in  1  one-cycle pulse from SAR: conversion complete
- sar_code  in  WIDTH  SAR final code, valid when sar_done=1
- comp  in  1  PD output; 1 = delay too long, 0 = delay too short
- code  out  WIDTH  registered delay control code
- code_valid  out  1  high in TRACK/LOCKED
- lock  out  1  registered lock flag
- relock_req  out  1  one-cycle pulse requesting SAR restart
- sat  out  1  high while code is at 0 or 2^WIDTH-1 and the last decision pushed past it

Behaviour:
- Reset (rst_n=0 at edge):
  - Outputs: code=0, code_valid=0, lock=0, relock_req=0, sat=0.
  - Internal state: state=IDLE, all counters 0.
  - Reset mid-operation aborts everything with no relock_req.
- States: IDLE, TRACK, LOCKED, RELOCK.
- IDLE:
  - comp is ignored.
  - If sar_done=1 at an edge: code←sar_code, state→TRACK, win/ones/hold/run counters←0, sat←0.
  - code_valid=1 from the following cycle.
- Window accumulation (TRACK and LOCKED):
  - Each edge samples comp. win_cnt increments and ones_cnt accumulates comp.
  - At the edge where win_cnt=WIN-1, decision uses total = ones_cnt + comp. win_cnt and ones_cnt clear at the same edge.
  - New code is visible the cycle after the WIN-th sample.
  - Decision latency = WIN cycles from first sample.
- Decision:
  - total ≥ TH_HI → DOWN: code-1, saturating at 0.
  - total ≤ TH_LO → UP: code+1, saturating at 2^WIDTH-1.
  - Otherwise → HOLD, code unchanged.
  - Saturated step: code unchanged, sat←1, still counts as a step of that direction. Any non-saturated decision clears sat.
- TRACK:
  - HOLD: hold_cnt+1. When hold_cnt reaches LOCK_HOLDS (i.e. the LOCK_HOLDS-th consecutive hold), state→LOCKED and lock←1 at that same edge.
  - UP/DOWN: hold_cnt←0.
- LOCKED:
  - lock stays 1.
  - HOLD: run_cnt←0.
  - Step in the same direction as the previous step: run_cnt+1. Step in the opposite direction, or the first step: run_cnt←1, dir←new direction.
  - When run_cnt reaches LOSS_STEPS: state→RELOCK, lock←0 at that edge.
- RELOCK:
  - Lasts exactly one cycle with relock_req=1, code_valid=0, code held.
  - Next edge: state→IDLE, relock_req←0.
- sar_done in TRACK/LOCKED/RELOCK is ignored.
- sar_done in IDLE coincident with reset: reset wins.
- Counters are sized to hold WIN, LOCK_HOLDS and LOSS_STEPS without wrap. hold_cnt saturates at LOCK_HOLDS.

Test Plan:
- Reset/capture: rst_n=0 for 2 cycles → all outputs 0. Then sar_done=1 with sar_code=0x155 → code=0x155 and code_valid=1 on the next cycle; lock=0.
- Tracking steps: after capture of 0x200, comp=1 constant for 8 cycles → code=0x1FF one cycle after the 8th sample. comp=0 for 8 cycles → code back to 0x200.
- Lock: after capture of 0x100, comp alternating 1/0 (4 ones per window) for 32 cycles → code stays 0x100, lock=1 at the edge of the 4th window decision, never before.
- Loss of lock: from LOCKED at 0x100, comp=1 for 24 cycles → code 0xFF, 0xFE, 0xFD. lock←0 and relock_req=1 for exactly one cycle after the 3rd step, then IDLE; the next sar_done is accepted.
- Saturation: capture 0x000, comp=1 for 16 cycles → code stays 0, sat=1 after the first window. Then comp=0 for 8 cycles → code=0x001, sat=0. Mirror the test at 0x3FF.
- Mid-operation reset: in LOCKED, assert rst_n=0 for one edge → code=0, lock=0, relock_req never pulses, state IDLE.
